// File: rtl/alu_control_mdu.sv
// EX-stage ALU control with an iterative multiply/divide unit and HI/LO.
// Decodes ALUOp/funct and stalls the pipeline while a mult/div iterates.
module alu_control_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic             valid,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       operation,
    output logic             Jr,
    output logic             illegal,
    output logic             stall,
    output logic             mdu_sel,
    output logic [WIDTH-1:0] mdu_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                fin;
    logic [2*WIDTH-1:0]  p_q, p_step, prod;
    logic [WIDTH-1:0]    m_q, dvd_q, hi_q, lo_q;
    logic                div_q, neg_q, rneg_q, dz_q;
    logic                is_r, is_md, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic                start, a_neg, b_neg;
    logic [WIDTH-1:0]    a_mag, b_mag;
    logic [WIDTH:0]      sum, t, diff;
    logic                ge;
    logic [WIDTH-1:0]    rq, rr, res_hi, res_lo;

    // ALU operation / Jr / illegal decode
    always_comb begin
        operation = 4'b0000;
        Jr        = 1'b0;
        illegal   = 1'b0;
        unique case (ALUOp)
            3'b000: operation = 4'b0010;
            3'b001: operation = 4'b0110;
            3'b100: operation = 4'b0000;
            3'b101: operation = 4'b0001;
            3'b010: begin
                unique case (funct)
                    6'b100000: operation = 4'b0010;
                    6'b100010: operation = 4'b0110;
                    6'b100100: operation = 4'b0000;
                    6'b100101: operation = 4'b0001;
                    6'b101010: operation = 4'b0111;
                    6'b000000: operation = 4'b0101;
                    6'b100111: operation = 4'b1100;
                    6'b001000: begin
                        operation = 4'b0010;
                        Jr        = 1'b1;
                    end
                    6'b011000, 6'b011001, 6'b011010, 6'b011011,
                    6'b010000, 6'b010010, 6'b010001, 6'b010011:
                        operation = 4'b0010;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign is_r    = (ALUOp == 3'b010);
    assign is_md   = is_r & (funct[5:2] == 4'b0110);
    assign is_mfhi = is_r & (funct == 6'b010000);
    assign is_mflo = is_r & (funct == 6'b010010);
    assign is_mthi = is_r & (funct == 6'b010001);
    assign is_mtlo = is_r & (funct == 6'b010011);

    assign start   = valid & is_md & (state_q == IDLE);
    assign stall   = start | (state_q == BUSY);
    assign mdu_sel = valid & (is_mfhi | is_mflo);
    assign mdu_out = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
    assign hi      = hi_q;
    assign lo      = lo_q;

    // funct[0]=1 selects the unsigned variants
    assign a_neg = ~funct[0] & rs_val[WIDTH-1];
    assign b_neg = ~funct[0] & rt_val[WIDTH-1];
    assign a_mag = a_neg ? -rs_val : rs_val;
    assign b_mag = b_neg ? -rt_val : rt_val;

    // One radix-2 step: shift-add multiply or restoring divide
    always_comb begin
        sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        t    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        ge   = (t >= {1'b0, m_q});
        diff = t - {1'b0, m_q};
        if (div_q)
            p_step = {(ge ? diff[WIDTH-1:0] : t[WIDTH-1:0]),
                      p_q[WIDTH-2:0], ge};
        else
            p_step = {sum, p_q[WIDTH-1:1]};
    end

    // Sign correction and divide-by-zero handling of the final step
    always_comb begin
        prod = neg_q ? -p_step : p_step;
        rq   = p_step[WIDTH-1:0];
        rr   = p_step[2*WIDTH-1:WIDTH];
        if (!div_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (dz_q) begin
            res_hi = dvd_q;
            res_lo = '1;
        end else begin
            res_hi = rneg_q ? -rr : rr;
            res_lo = neg_q ? -rq : rq;
        end
    end

    // FSM next state and iteration counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = BUSY;
                cnt_d   = '0;
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    fin     = 1'b1;
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand latch on start, partial result update while busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q    <= '0;
            m_q    <= '0;
            dvd_q  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (start) begin
            p_q    <= {{WIDTH{1'b0}}, a_mag};
            m_q    <= b_mag;
            dvd_q  <= rs_val;
            div_q  <= funct[1];
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            dz_q   <= funct[1] & (rt_val == '0);
        end else if (state_q == BUSY) begin
            p_q <= p_step;
        end
    end

    // HI/LO: result writeback or mthi/mtlo moves
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fin) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (valid & ~stall & is_mthi) begin
            hi_q <= rs_val;
        end else if (valid & ~stall & is_mtlo) begin
            lo_q <= rs_val;
        end
    end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode table plus mult/div sequences.
// Uses a WIDTH=8 and a WIDTH=32 instance side by side.
module tb_alu_control_mdu;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef struct packed {
        logic [2:0] aluop;
        logic [5:0] funct;
        logic [3:0] op;
        logic       jr;
        logic       ill;
    } dvec_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [2:0]  a8, a32;
    logic [5:0]  f8, f32;
    logic        v8, v32;
    logic [7:0]  rs8, rt8;
    logic [31:0] rs32, rt32;
    logic [3:0]  op8, op32;
    logic        jr8, jr32, il8, il32, st8, st32, ms8, ms32;
    logic [7:0]  mo8, hi8, lo8;
    logic [31:0] mo32, hi32, lo32;

    int n_chk  = 0;
    int n_fail = 0;
    int n;
    dvec_t dv[23];

    always #5 clk = ~clk;

    alu_control_mdu #(.WIDTH(8)) d8 (
        .clk(clk), .rst_n(rst_n), .ALUOp(a8), .funct(f8), .valid(v8),
        .rs_val(rs8), .rt_val(rt8), .operation(op8), .Jr(jr8),
        .illegal(il8), .stall(st8), .mdu_sel(ms8), .mdu_out(mo8),
        .hi(hi8), .lo(lo8)
    );

    alu_control_mdu #(.WIDTH(32)) d32 (
        .clk(clk), .rst_n(rst_n), .ALUOp(a32), .funct(f32), .valid(v32),
        .rs_val(rs32), .rt_val(rt32), .operation(op32), .Jr(jr32),
        .illegal(il32), .stall(st32), .mdu_sel(ms32), .mdu_out(mo32),
        .hi(hi32), .lo(lo32)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an R-type op and count stalled cycles; returns at the
    // negedge of the first non-stalled cycle (the DONE cycle).
    task automatic run_op(input bit w32, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          output int cnt);
        cnt = 0;
        if (w32) begin
            a32 = 3'b010; f32 = f; v32 = 1'b1; rs32 = a; rt32 = b;
        end else begin
            a8 = 3'b010; f8 = f; v8 = 1'b1; rs8 = a[7:0]; rt8 = b[7:0];
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((w32 ? st32 : st8) == 1'b0) break;
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        dv[0]  = '{3'b000, 6'b000000, 4'b0010, 1'b0, 1'b0};
        dv[1]  = '{3'b001, 6'b000000, 4'b0110, 1'b0, 1'b0};
        dv[2]  = '{3'b100, 6'b000000, 4'b0000, 1'b0, 1'b0};
        dv[3]  = '{3'b101, 6'b000000, 4'b0001, 1'b0, 1'b0};
        dv[4]  = '{3'b011, 6'b100000, 4'b0000, 1'b0, 1'b1};
        dv[5]  = '{3'b110, 6'b100000, 4'b0000, 1'b0, 1'b1};
        dv[6]  = '{3'b111, 6'b100000, 4'b0000, 1'b0, 1'b1};
        dv[7]  = '{3'b010, 6'b100000, 4'b0010, 1'b0, 1'b0};
        dv[8]  = '{3'b010, 6'b100010, 4'b0110, 1'b0, 1'b0};
        dv[9]  = '{3'b010, 6'b100100, 4'b0000, 1'b0, 1'b0};
        dv[10] = '{3'b010, 6'b100101, 4'b0001, 1'b0, 1'b0};
        dv[11] = '{3'b010, 6'b101010, 4'b0111, 1'b0, 1'b0};
        dv[12] = '{3'b010, 6'b000000, 4'b0101, 1'b0, 1'b0};
        dv[13] = '{3'b010, 6'b100111, 4'b1100, 1'b0, 1'b0};
        dv[14] = '{3'b010, 6'b001000, 4'b0010, 1'b1, 1'b0};
        dv[15] = '{3'b010, F_MULT,    4'b0010, 1'b0, 1'b0};
        dv[16] = '{3'b010, F_MULTU,   4'b0010, 1'b0, 1'b0};
        dv[17] = '{3'b010, F_DIV,     4'b0010, 1'b0, 1'b0};
        dv[18] = '{3'b010, F_DIVU,    4'b0010, 1'b0, 1'b0};
        dv[19] = '{3'b010, F_MFHI,    4'b0010, 1'b0, 1'b0};
        dv[20] = '{3'b010, F_MFLO,    4'b0010, 1'b0, 1'b0};
        dv[21] = '{3'b010, F_MTHI,    4'b0010, 1'b0, 1'b0};
        dv[22] = '{3'b010, 6'b111111, 4'b0000, 1'b0, 1'b1};

        rst_n = 1'b0;
        a8 = '0; f8 = '0; v8 = 1'b0; rs8 = '0; rt8 = '0;
        a32 = '0; f32 = '0; v32 = 1'b0; rs32 = '0; rt32 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall8", 32'(st8), 32'h0);
        chk("rst_hi8", 32'(hi8), 32'h0);
        chk("rst_lo8", 32'(lo8), 32'h0);
        chk("rst_stall32", 32'(st32), 32'h0);
        chk("rst_hi32", hi32, 32'h0);
        chk("rst_lo32", lo32, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            a32 = dv[i].aluop;
            f32 = dv[i].funct;
            #1;
            chk($sformatf("dec%0d", i), 32'({op32, jr32, il32}),
                32'({dv[i].op, dv[i].jr, dv[i].ill}));
        end

        @(posedge clk); #1;
        run_op(1'b0, F_MULT, 32'hFD, 32'h05, n);
        chk("mult8_stall", 32'(n), 32'd9);
        chk("mult8_hi", 32'(hi8), 32'hFF);
        chk("mult8_lo", 32'(lo8), 32'hF1);
        @(posedge clk); #1;
        f8 = F_MFLO;
        @(negedge clk);
        chk("mflo_stall", 32'(st8), 32'h0);
        chk("mflo_sel", 32'(ms8), 32'h1);
        chk("mflo_out", 32'(mo8), 32'hF1);
        f8 = F_MFHI;
        #1;
        chk("mfhi_out", 32'(mo8), 32'hFF);
        @(posedge clk); #1;
        v8 = 1'b0;

        run_op(1'b1, F_DIV, 32'hFFFFFFF9, 32'd2, n);
        chk("div32_stall", 32'(n), 32'd33);
        chk("div32_lo", lo32, 32'hFFFFFFFD);
        chk("div32_hi", hi32, 32'hFFFFFFFF);
        @(posedge clk); #1;
        run_op(1'b1, F_DIVU, 32'd7, 32'd0, n);
        chk("dz32_stall", 32'(n), 32'd33);
        chk("dz32_lo", lo32, 32'hFFFFFFFF);
        chk("dz32_hi", hi32, 32'h7);
        @(posedge clk); #1;
        v32 = 1'b0;

        run_op(1'b0, F_DIV, 32'h80, 32'hFF, n);
        chk("ovf8_stall", 32'(n), 32'd9);
        chk("ovf8_lo", 32'(lo8), 32'h80);
        chk("ovf8_hi", 32'(hi8), 32'h00);
        @(posedge clk); #1;

        run_op(1'b0, F_MULTU, 32'hFF, 32'hFF, n);
        chk("mu1_stall", 32'(n), 32'd9);
        chk("mu1_hi", 32'(hi8), 32'hFE);
        chk("mu1_lo", 32'(lo8), 32'h01);
        @(posedge clk); #1;
        run_op(1'b0, F_MULTU, 32'd2, 32'd3, n);
        chk("mu2_stall", 32'(n), 32'd9);
        chk("mu2_hi", 32'(hi8), 32'h00);
        chk("mu2_lo", 32'(lo8), 32'h06);
        @(posedge clk); #1;
        v8 = 1'b0;

        a8 = 3'b010; f8 = F_MULT; rs8 = 8'd7; rt8 = 8'd9; v8 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        v8 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstb_stall", 32'(st8), 32'h0);
        chk("rstb_hi", 32'(hi8), 32'h0);
        chk("rstb_lo", 32'(lo8), 32'h0);
        @(posedge clk); #1;
        run_op(1'b0, F_MULT, 32'd7, 32'd9, n);
        chk("rmul_stall", 32'(n), 32'd9);
        chk("rmul_hi", 32'(hi8), 32'h00);
        chk("rmul_lo", 32'(lo8), 32'h3F);
        @(posedge clk); #1;

        f8 = F_MTHI; rs8 = 8'h5A; v8 = 1'b1;
        @(posedge clk); #1;
        chk("mthi_v1", 32'(hi8), 32'h5A);
        v8 = 1'b0; rs8 = 8'hA5;
        @(posedge clk); #1;
        chk("mthi_v0", 32'(hi8), 32'h5A);
        f8 = F_MTLO; rs8 = 8'h3C; v8 = 1'b1;
        @(posedge clk); #1;
        chk("mtlo_v1", 32'(lo8), 32'h3C);
        f8 = F_MFHI;
        #1;
        chk("mfhi_sel", 32'(ms8), 32'h1);
        chk("mfhi_val", 32'(mo8), 32'h5A);
        v8 = 1'b0;
        #1;
        chk("mfhi_sel_v0", 32'(ms8), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
